// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel-clock divider
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clock,
    input  logic          res,
    input  logic          enable,
    output logic          pix_tick,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Divider needs at least one bit even when CLK_DIV is 1.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          pix_tick_q, pix_tick_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          tick;

    // Next-state: divider, raster counters, and outputs decoded from the next counter values
    always_comb begin
        tick          = enable && (div_q == DIV_LAST);
        div_d         = div_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;

        if (enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Sync levels only move while running; a paused raster keeps its last level.
        if (enable) begin
            hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? H_POL : ~H_POL;
            vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? V_POL : ~V_POL;
        end

        pix_tick_d    = tick;
        line_start_d  = tick && (hcount_d == '0);
        frame_start_d = line_start_d && (vcount_d == '0);
        active_d      = enable && (hcount_d < H_VIS) && (vcount_d < V_VIS);
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
